// File: rtl/tx_engine_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and the parity
// function used by both the transmit engine and the receiver's error check.
package tx_engine_pkg;

    localparam int FRAME_BITS = 11;
    localparam int BAUD_W     = 18;
    localparam int BIDX_W     = 4;
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(FRAME_BITS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    // Even parity over the data bits in use, inverted for odd parity.
    function automatic logic uart_parity(input logic [7:0] data,
                                         input logic       bit8_en,
                                         input logic       odd_en);
        logic p;
        p = bit8_en ? ^data : ^data[6:0];
        return p ^ odd_en;
    endfunction

endpackage

// File: rtl/tx_engine_if.sv
// Core-side bus of the UART transmit engine: write strobe, byte, line
// configuration and the serial/status outputs.
interface tx_engine_if;
    import tx_engine_pkg::*;

    logic              wr_strb;
    logic [7:0]        Tx_data;
    logic              parity_en;
    logic              bit8_en;
    logic              odd_en;
    logic [BAUD_W-1:0] Baud_val;
    logic              Tx;
    logic              Tx_rdy;
    logic              Tx_done;

    modport master (
        output wr_strb, Tx_data, parity_en, bit8_en, odd_en, Baud_val,
        input  Tx, Tx_rdy, Tx_done
    );

    modport slave (
        input  wr_strb, Tx_data, parity_en, bit8_en, odd_en, Baud_val,
        output Tx, Tx_rdy, Tx_done
    );

endinterface

// File: rtl/tx_bit_timer.sv
// Bit-time counter: while run is high, raises btu once every Baud_val clocks
// (Baud_val of 0 behaves as 1).
module tx_bit_timer
    import tx_engine_pkg::*;
#(
    parameter int CNT_W = BAUD_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             run,
    input  logic [CNT_W-1:0] Baud_val,
    output logic             btu
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;
    logic             w_wrap;

    // >= rather than == so a mid-frame drop in Baud_val cannot strand the counter.
    assign w_limit = (Baud_val == '0) ? '0 : Baud_val - CNT_W'(1);
    assign w_wrap  = (r_cnt >= w_limit);
    assign btu     = run & w_wrap;

    always_ff @(posedge Clk) begin
        if (Rst || !run) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_engine.sv
// UART transmit engine: latches one byte plus line configuration per accepted
// strobe and shifts an 11-bit-time RS232 frame out LSB-first on Tx.
module tx_engine
    import tx_engine_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    tx_engine_if.slave  bus
);

    tx_state_e               r_state;
    tx_state_e               w_state_nxt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [FRAME_BITS-1:0]   w_frame;
    logic [BIDX_W-1:0]       r_bidx;
    logic                    r_done;
    logic                    w_par;
    logic                    w_btu;
    logic                    w_run;
    logic                    w_load;
    logic                    w_last;

    tx_bit_timer #(.CNT_W(BAUD_W)) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .run      (w_run),
        .Baud_val (bus.Baud_val),
        .btu      (w_btu)
    );

    // Slots not claimed by data or parity become extra stop bits.
    always_comb begin
        w_par      = uart_parity(bus.Tx_data, bus.bit8_en, bus.odd_en);
        w_frame    = '1;
        w_frame[0] = 1'b0;
        w_frame[7:1] = bus.Tx_data[6:0];
        if (bus.bit8_en) begin
            w_frame[8] = bus.Tx_data[7];
        end else if (bus.parity_en) begin
            w_frame[8] = w_par;
        end
        if (bus.bit8_en && bus.parity_en) begin
            w_frame[9] = w_par;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.wr_strb) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_run = 1'b1;
                if (w_btu && (r_bidx == LAST_BIT)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_shift <= '1;
            r_bidx  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_load) begin
                r_shift <= w_frame;
                r_bidx  <= '0;
            end else if (w_run && w_btu) begin
                r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
                r_bidx  <= w_last ? '0 : r_bidx + BIDX_W'(1);
            end
        end
    end

    assign bus.Tx      = r_shift[0];
    assign bus.Tx_rdy  = (r_state == ST_IDLE);
    assign bus.Tx_done = r_done;

endmodule

// File: tb/tb_tx_engine.sv
// Directed and randomized bench for tx_engine; expected line waveforms come
// from a frame model built bit-by-bit from the RS232 framing rules.
module tb_tx_engine;
    import tx_engine_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    tx_engine_if bus_if();

    tx_engine dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if.slave)
    );

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Start bit, data LSB-first, optional parity, then stop-fill to 11 slots.
    function automatic logic [FRAME_BITS-1:0] model_frame(input logic [7:0] d,
                                                          input logic pe, b8, od);
        bit q[$];
        int n;
        int ones;
        logic [FRAME_BITS-1:0] f;
        n    = b8 ? 8 : 7;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) q.push_back(bit'(((ones % 2) == 1) != od));
        while (q.size() < FRAME_BITS) q.push_back(1'b1);
        for (int i = 0; i < FRAME_BITS; i++) f[i] = q[i];
        return f;
    endfunction

    task automatic do_frame(input string nm, input logic [7:0] d,
                            input logic pe, input logic b8, input logic od,
                            input logic [BAUD_W-1:0] bv, input int busy_k,
                            input bit pre, input bit chain, input logic [7:0] nd);
        logic [FRAME_BITS-1:0] f;
        int b;
        f = model_frame(d, pe, b8, od);
        b = (bv == '0) ? 1 : int'(bv);
        if (!pre) begin
            @(negedge Clk);
            bus_if.wr_strb   = 1'b1;
            bus_if.Tx_data   = d;
            bus_if.parity_en = pe;
            bus_if.bit8_en   = b8;
            bus_if.odd_en    = od;
            bus_if.Baud_val  = bv;
        end
        @(posedge Clk);
        #1;
        bus_if.wr_strb   = 1'b0;
        bus_if.Tx_data   = 8'($urandom);
        bus_if.parity_en = 1'($urandom);
        bus_if.bit8_en   = 1'($urandom);
        bus_if.odd_en    = 1'($urandom);
        for (int k = 0; k < 11 * b; k++) begin
            @(negedge Clk);
            chk($sformatf("%s c%0d tx", nm, k), bus_if.Tx, f[k / b]);
            chk($sformatf("%s c%0d rdy", nm, k), bus_if.Tx_rdy, 1'b0);
            chk($sformatf("%s c%0d done", nm, k), bus_if.Tx_done, 1'b0);
            if (k == busy_k) begin
                bus_if.wr_strb = 1'b1;
                bus_if.Tx_data = 8'hFF;
            end else if (k == busy_k + 1) begin
                bus_if.wr_strb = 1'b0;
            end
        end
        @(negedge Clk);
        chk({nm, " end tx"}, bus_if.Tx, 1'b1);
        chk({nm, " end rdy"}, bus_if.Tx_rdy, 1'b1);
        chk({nm, " end done"}, bus_if.Tx_done, 1'b1);
        if (chain) begin
            bus_if.wr_strb   = 1'b1;
            bus_if.Tx_data   = nd;
            bus_if.parity_en = pe;
            bus_if.bit8_en   = b8;
            bus_if.odd_en    = od;
        end else begin
            @(negedge Clk);
            chk({nm, " post done"}, bus_if.Tx_done, 1'b0);
            chk({nm, " post rdy"}, bus_if.Tx_rdy, 1'b1);
            chk({nm, " post tx"}, bus_if.Tx, 1'b1);
        end
    endtask

    initial begin
        logic [7:0]        d;
        logic [7:0]        nd;
        logic              pe;
        logic              b8;
        logic              od;
        logic [BAUD_W-1:0] bv;
        int                b;
        int                busy;
        bit                pre;
        bit                chain;

        Rst              = 1'b1;
        bus_if.wr_strb   = 1'b0;
        bus_if.Tx_data   = 8'h00;
        bus_if.parity_en = 1'b0;
        bus_if.bit8_en   = 1'b1;
        bus_if.odd_en    = 1'b0;
        bus_if.Baud_val  = 18'd4;

        // Reset then idle
        @(negedge Clk);
        @(negedge Clk);
        chk("rst tx", bus_if.Tx, 1'b1);
        chk("rst rdy", bus_if.Tx_rdy, 1'b1);
        chk("rst done", bus_if.Tx_done, 1'b0);
        Rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            chk($sformatf("idle%0d tx", i), bus_if.Tx, 1'b1);
            chk($sformatf("idle%0d rdy", i), bus_if.Tx_rdy, 1'b1);
            chk($sformatf("idle%0d done", i), bus_if.Tx_done, 1'b0);
        end

        // Directed frames
        do_frame("8N1", 8'h55, 1'b0, 1'b1, 1'b0, 18'd4, -1, 1'b0, 1'b0, 8'h00);
        do_frame("8E1", 8'hA5, 1'b1, 1'b1, 1'b0, 18'd3, -1, 1'b0, 1'b0, 8'h00);
        do_frame("7O1", 8'hC1, 1'b1, 1'b0, 1'b1, 18'd2, -1, 1'b0, 1'b0, 8'h00);
        do_frame("busy", 8'h3C, 1'b1, 1'b1, 1'b1, 18'd3, 7, 1'b0, 1'b1, 8'h96);
        do_frame("b2b", 8'h96, 1'b1, 1'b1, 1'b1, 18'd3, -1, 1'b1, 1'b0, 8'h00);
        do_frame("baud0", 8'hE7, 1'b0, 1'b1, 1'b0, 18'd0, -1, 1'b0, 1'b0, 8'h00);

        // Mid-frame reset during bit 4
        @(negedge Clk);
        bus_if.wr_strb   = 1'b1;
        bus_if.Tx_data   = 8'h00;
        bus_if.parity_en = 1'b0;
        bus_if.bit8_en   = 1'b1;
        bus_if.Baud_val  = 18'd4;
        @(posedge Clk);
        #1;
        bus_if.wr_strb = 1'b0;
        repeat (17) @(negedge Clk);
        chk("midrst bit4 tx", bus_if.Tx, 1'b0);
        chk("midrst bit4 rdy", bus_if.Tx_rdy, 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("midrst tx", bus_if.Tx, 1'b1);
        chk("midrst rdy", bus_if.Tx_rdy, 1'b1);
        chk("midrst done", bus_if.Tx_done, 1'b0);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midrst idle tx", bus_if.Tx, 1'b1);
        chk("midrst idle rdy", bus_if.Tx_rdy, 1'b1);
        do_frame("postrst", 8'h81, 1'b1, 1'b0, 1'b0, 18'd2, -1, 1'b0, 1'b0, 8'h00);

        // Randomized frames with busy strobes and back-to-back chaining
        pre = 1'b0;
        nd  = 8'h00;
        pe  = 1'b0;
        b8  = 1'b1;
        od  = 1'b0;
        bv  = 18'd1;
        for (int i = 0; i < 25; i++) begin
            if (pre) begin
                d = nd;
            end else begin
                d  = 8'($urandom);
                pe = 1'($urandom);
                b8 = 1'($urandom);
                od = 1'($urandom);
                bv = BAUD_W'($urandom_range(0, 5));
            end
            b     = (bv == '0) ? 1 : int'(bv);
            busy  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11 * b - 2)) : -1;
            chain = (i < 24) && ($urandom_range(0, 1) == 1);
            nd    = 8'($urandom);
            do_frame($sformatf("rnd%0d", i), d, pe, b8, od, bv, busy, pre, chain, nd);
            pre = chain;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_engine.md
Name: tx_engine

Overview:
- UART transmit engine; transmit-side counterpart of the core-logic receive engine.
- Accepts one byte per write strobe from the core/register interface.
- Serialises the byte LSB-first onto Tx as an RS232 frame: start bit, 7 or 8 data bits, optional even/odd parity, stop bit(s).
- Uses the same 18-bit Baud_val and the same parity_en/bit8_en/odd_en configuration as the receiver.

Parameters:
- FRAME_BITS, 11, bit times per frame (start + 9 payload/parity slots + stop); fixed width of the output shift register.
- BAUD_W, 18, width of Baud_val and of the bit-time counter.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset; one clock domain, synchronous, active-high.
- wr_strb  in  1  one-cycle write strobe; Tx_data valid in the same cycle.
- Tx_data  in  8  byte to send; bit 7 ignored when bit8_en=0.
- parity_en  in  1  1 = append a parity bit.
- bit8_en  in  1  1 = 8 data bits, 0 = 7 data bits.
- odd_en  in  1  1 = odd parity, 0 = even parity.
- Baud_val  in  BAUD_W  clocks per bit time.
- Tx  out  1  serial output; idles high.
- Tx_rdy  out  1  1 = idle, next wr_strb is accepted.
- Tx_done  out  1  one-cycle pulse when the final stop-bit time ends.

Behaviour:
- Reset (synchronous, Rst=1 at a Clk edge):
  - state=IDLE; shift register all 1s; Tx=1; Tx_rdy=1; Tx_done=0; counters=0.
  - Reset mid-frame aborts the frame immediately; Tx returns high on the next edge.
- Parity: P = ^(data bits in use, 7 or 8), then inverted if odd_en=1.
- Frame vector, transmitted bit0 first:
  - bit0 = 0 (start).
  - bits1..7 = Tx_data[6:0].
  - bit8 = Tx_data[7] if bit8_en; else P if parity_en; else 1.
  - bit9 = P if (bit8_en & parity_en); else 1.
  - bit10 = 1 (stop).
  - Every frame is always 11 bit times; unused slots are extra stop bits.
- Configuration inputs and Tx_data are sampled only at the accepting edge. Later changes do not affect the frame in flight.
- FSM states: IDLE and SHIFT.
  - IDLE: on wr_strb & Tx_rdy, at that edge: load the frame vector into the shift register, bit index=0, bit-time counter=0, Tx_rdy=0, go to SHIFT.
  - SHIFT: Tx = shift_reg[0], registered, so the start bit appears on Tx in the cycle after the strobe.
  - Bit-time counter increments every clock. When it reaches B-1 (B = Baud_val, treated as 1 when Baud_val=0), it wraps to 0 and raises btu.
  - On btu: shift right with 1-fill and increment bit index.
  - On btu with bit index=10: go to IDLE, Tx_rdy=1, Tx_done=1 for exactly that one cycle, Tx=1.
- Timing:
  - Each bit is held for exactly B clocks.
  - Tx_rdy is low for exactly 11*B cycles after the accepting edge.
  - A strobe in the same cycle Tx_rdy rises is accepted, giving back-to-back frames with no idle gap.
- wr_strb while Tx_rdy=0 is ignored: no state change, no data corruption.
- Baud_val changes mid-frame are undefined-rate but must not hang the FSM. The counter compares with >= (B-1).

Decomposition:
- Shared UART package holds:
  - state encoding (IDLE, SHIFT);
  - FRAME_BITS and the last-bit index (10);
  - the parity function (data, bit8_en, odd_en), shared with the receiver for error checking.
- One natural sub-module: tx_bit_timer (Clk, Rst, run, Baud_val -> btu), the counter that produces the bit-time tick.
- The frame builder, shift register and FSM stay in tx_engine.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles, release -> Tx=1, Tx_rdy=1, Tx_done=0 held for 50 cycles.
- 8N1, Baud_val=4, bit8_en=1, parity_en=0, Tx_data=0x55 -> Tx per 4-clock bit: 0,1,0,1,0,1,0,1,0,1,1; Tx_rdy low 44 cycles; one Tx_done pulse.
- 8E1, Baud_val=3, Tx_data=0xA5, odd_en=0 -> data LSB-first 1,0,1,0,0,1,0,1; parity 0; stop 1; frame 0,10100101,0,1.
- 7O1, Baud_val=2, bit8_en=0, Tx_data=0xC1 -> data 1,0,0,0,0,0,1 (bit7 ignored); parity 1; then 1,1; 22-cycle busy.
- Busy write: second wr_strb with 0xFF mid-frame -> ignored, first frame bit-exact. Strobe on the Tx_rdy-rising cycle -> next start bit immediately, no idle gap.
- Mid-frame reset and Baud_val=0: Rst during bit 4 -> Tx=1 and Tx_rdy=1 the next cycle. Baud_val=0 -> 1 clock per bit, 11-cycle frame.
